// File: rtl/serial_tx_gen.sv
// -----------------------------------------------------------------------------
// serial_tx_gen
// Self-timed multi-lane serial transmitter. A frame request latches the data
// words and the timing set, then one shared timing engine drives every lane:
// an optional lead-in at the idle level, nbits bits of n1 cycles each, and a
// gap of n2 cycles at the idle level. The frame plus gap repeats n3 extra
// times, and ack pulses for one cycle at the end.
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous active-high reset (aborts a frame, no ack)
//   start    in   frame request, taken only while idle
//   data     in   NCH*DATA_W lane words, lane c = data[c*DATA_W +: DATA_W]
//   nbits    in   bits per frame (clamped to DATA_W)
//   y0       in   idle / lead-in / gap line level
//   n0       in   lead-in cycles, once per request
//   n1       in   cycles per bit (0 acts as 1)
//   n2       in   gap cycles after each frame
//   n3       in   extra repeats (frame is sent n3+1 times)
//   busy     out  high from acceptance until ack
//   ack      out  one-cycle completion pulse
//   y        out  registered serial lane outputs
//   bit_idx  out  data index currently on y, 0 outside bit cells
// -----------------------------------------------------------------------------
module serial_tx_gen #(
   parameter int DATA_W    = 256,
   parameter int NBITS_W   = 8,
   parameter int CNT_W     = 32,
   parameter int NCH       = 1,
   parameter int LSB_FIRST = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [NCH*DATA_W-1:0] data,
   input  logic [NBITS_W-1:0]    nbits,
   input  logic                  y0,
   input  logic [CNT_W-1:0]      n0,
   input  logic [CNT_W-1:0]      n1,
   input  logic [CNT_W-1:0]      n2,
   input  logic [CNT_W-1:0]      n3,
   output logic                  busy,
   output logic                  ack,
   output logic [NCH-1:0]        y,
   output logic [NBITS_W-1:0]    bit_idx
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEAD,
      S_BIT,
      S_GAP,
      S_DONE
   } state_t;

   function automatic logic [NBITS_W-1:0] clamp_nbits(input logic [NBITS_W-1:0] v);
      if (32'(v) > 32'(DATA_W)) return NBITS_W'(DATA_W);
      return v;
   endfunction

   function automatic logic [CNT_W-1:0] clamp_n1(input logic [CNT_W-1:0] v);
      if (v == '0) return CNT_W'(1);
      return v;
   endfunction

   state_t                r_state;
   state_t                w_state_nx;
   logic [CNT_W-1:0]      r_cnt;
   logic [CNT_W-1:0]      w_cnt_nx;
   logic [NBITS_W-1:0]    r_idx;
   logic [NBITS_W-1:0]    w_idx_nx;
   logic [CNT_W-1:0]      r_rep;
   logic [CNT_W-1:0]      w_rep_nx;

   // Shadow copies of the request, held for the whole transfer
   logic [NCH*DATA_W-1:0] r_data;
   logic [NBITS_W-1:0]    r_nbits;
   logic                  r_y0;
   logic [CNT_W-1:0]      r_n1;
   logic [CNT_W-1:0]      r_n2;

   logic                  w_accept;
   logic [NBITS_W-1:0]    w_nb_cfg;
   logic [CNT_W-1:0]      w_n1_cfg;
   logic [CNT_W-1:0]      w_n2_cfg;
   logic                  w_last_bit;
   logic                  w_go_frame;
   logic                  w_go_endgap;
   logic [NCH-1:0]        w_bits;

   assign w_accept = (r_state == S_IDLE) && start;

   // On the acceptance edge the shadows are not loaded yet, so the first
   // phase decision has to be taken from the (clamped) live inputs.
   assign w_nb_cfg = (r_state == S_IDLE) ? clamp_nbits(nbits) : r_nbits;
   assign w_n1_cfg = (r_state == S_IDLE) ? clamp_n1(n1)       : r_n1;
   assign w_n2_cfg = (r_state == S_IDLE) ? n2                 : r_n2;

   assign w_last_bit = (LSB_FIRST != 0) ? (r_idx == r_nbits - NBITS_W'(1))
                                        : (r_idx == '0);

   // -------------------------------------------------------------------------
   // Next-state logic. r_cnt holds the cycles still to spend in the current
   // phase minus one, so a phase ends on the cycle it reads zero.
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nx  = r_state;
      w_cnt_nx    = r_cnt;
      w_idx_nx    = r_idx;
      w_rep_nx    = r_rep;
      w_go_frame  = 1'b0;
      w_go_endgap = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_rep_nx = n3;
               if (n0 != '0) begin
                  w_state_nx = S_LEAD;
                  w_cnt_nx   = n0 - CNT_W'(1);
               end else begin
                  w_go_frame = 1'b1;
               end
            end
         end
         S_LEAD: begin
            if (r_cnt != '0) w_cnt_nx = r_cnt - CNT_W'(1);
            else             w_go_frame = 1'b1;
         end
         S_BIT: begin
            if (r_cnt != '0) begin
               w_cnt_nx = r_cnt - CNT_W'(1);
            end else if (!w_last_bit) begin
               w_cnt_nx = r_n1 - CNT_W'(1);
               w_idx_nx = (LSB_FIRST != 0) ? r_idx + NBITS_W'(1) : r_idx - NBITS_W'(1);
            end else if (r_n2 != '0) begin
               w_state_nx = S_GAP;
               w_cnt_nx   = r_n2 - CNT_W'(1);
            end else begin
               w_go_endgap = 1'b1;
            end
         end
         S_GAP: begin
            if (r_cnt != '0) w_cnt_nx = r_cnt - CNT_W'(1);
            else             w_go_endgap = 1'b1;
         end
         S_DONE: begin
            w_state_nx = S_IDLE;
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase

      // End of a gap (possibly zero length): repeat without lead-in or finish
      if (w_go_endgap) begin
         if (r_rep != '0) begin
            w_rep_nx   = r_rep - CNT_W'(1);
            w_go_frame = 1'b1;
         end else begin
            w_state_nx = S_DONE;
         end
      end

      // Frame start; an empty frame with no gap has no cycles at all, so
      // the repeats collapse and the transfer completes immediately.
      if (w_go_frame) begin
         if (w_nb_cfg != '0) begin
            w_state_nx = S_BIT;
            w_cnt_nx   = w_n1_cfg - CNT_W'(1);
            w_idx_nx   = (LSB_FIRST != 0) ? '0 : w_nb_cfg - NBITS_W'(1);
         end else if (w_n2_cfg != '0) begin
            w_state_nx = S_GAP;
            w_cnt_nx   = w_n2_cfg - CNT_W'(1);
         end else begin
            w_state_nx = S_DONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_rep   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_idx   <= w_idx_nx;
         r_rep   <= w_rep_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_data  <= data;
         r_nbits <= clamp_nbits(nbits);
         r_y0    <= y0;
         r_n1    <= clamp_n1(n1);
         r_n2    <= n2;
      end
   end

   // Per-lane bit select at the shared index
   always_comb begin
      w_bits = '0;
      for (int c = 0; c < NCH; c++) begin
         for (int i = 0; i < DATA_W; i++) begin
            if (r_idx == NBITS_W'(i)) w_bits[c] = r_data[c*DATA_W + i];
         end
      end
   end

   // -------------------------------------------------------------------------
   // Output register stage: outputs trail the phase state by one cycle,
   // which places the first bit at edge k+1+n0 after acceptance at edge k.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         y       <= '0;
         busy    <= 1'b0;
         ack     <= 1'b0;
         bit_idx <= '0;
      end else begin
         case (r_state)
            S_LEAD, S_GAP: begin
               y       <= {NCH{r_y0}};
               busy    <= 1'b1;
               ack     <= 1'b0;
               bit_idx <= '0;
            end
            S_BIT: begin
               y       <= w_bits;
               busy    <= 1'b1;
               ack     <= 1'b0;
               bit_idx <= r_idx;
            end
            S_DONE: begin
               y       <= {NCH{r_y0}};
               busy    <= 1'b0;
               ack     <= 1'b1;
               bit_idx <= '0;
            end
            default: begin
               y       <= {NCH{y0}};
               busy    <= 1'b0;
               ack     <= 1'b0;
               bit_idx <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_tx_gen.sv
// -----------------------------------------------------------------------------
// tb_serial_tx_gen
// Two instances (MSB-first and LSB-first, two lanes each, 16-bit words) share
// the same stimulus. A reference model expands each accepted request into the
// full per-cycle output sequence and a compare process checks every cycle.
// Directed frames pin ack latency and transmitted bit patterns to literals.
// -----------------------------------------------------------------------------
module tb_serial_tx_gen;

   localparam int DW = 16;
   localparam int NW = 8;
   localparam int CW = 16;
   localparam int NC = 2;

   logic              clk   = 1'b0;
   logic              rst   = 1'b1;
   logic              start = 1'b0;
   logic              y0    = 1'b0;
   logic [NC*DW-1:0]  data  = '0;
   logic [NW-1:0]     nbits = '0;
   logic [CW-1:0]     n0 = '0, n1 = '0, n2 = '0, n3 = '0;

   logic              busy_m, ack_m, busy_l, ack_l;
   logic [NC-1:0]     y_m, y_l;
   logic [NW-1:0]     idx_m, idx_l;

   always #5 clk = ~clk;

   serial_tx_gen #(.DATA_W(DW), .NBITS_W(NW), .CNT_W(CW), .NCH(NC), .LSB_FIRST(0)) u_msb (
      .clk(clk), .rst(rst), .start(start), .data(data), .nbits(nbits), .y0(y0),
      .n0(n0), .n1(n1), .n2(n2), .n3(n3),
      .busy(busy_m), .ack(ack_m), .y(y_m), .bit_idx(idx_m)
   );

   serial_tx_gen #(.DATA_W(DW), .NBITS_W(NW), .CNT_W(CW), .NCH(NC), .LSB_FIRST(1)) u_lsb (
      .clk(clk), .rst(rst), .start(start), .data(data), .nbits(nbits), .y0(y0),
      .n0(n0), .n1(n1), .n2(n2), .n3(n3),
      .busy(busy_l), .ack(ack_l), .y(y_l), .bit_idx(idx_l)
   );

   typedef struct {
      logic [NC-1:0] ym;
      logic [NC-1:0] yl;
      logic          busy;
      logic          ack;
      logic [NW-1:0] im;
      logic [NW-1:0] il;
   } exp_t;

   exp_t q[$];
   exp_t ex;
   int   vectors     = 0;
   int   miscompares = 0;

   task automatic push(input logic [NC-1:0] ym, input logic [NC-1:0] yl, input logic b,
                       input logic a, input int im, input int il);
      exp_t t;
      t.ym = ym; t.yl = yl; t.busy = b; t.ack = a; t.im = NW'(im); t.il = NW'(il);
      q.push_back(t);
   endtask

   // Expand a request into the exact output sequence for edges k+1 .. ack
   task automatic build();
      int nbc, n1c, im;
      logic [DW-1:0] l0, l1;
      nbc = (int'(nbits) > DW) ? DW : int'(nbits);
      n1c = (n1 == '0) ? 1 : int'(n1);
      l0  = data[DW-1:0];
      l1  = data[2*DW-1:DW];
      for (int c = 0; c < int'(n0); c++) push({y0, y0}, {y0, y0}, 1'b1, 1'b0, 0, 0);
      for (int r = 0; r <= int'(n3); r++) begin
         for (int i = 0; i < nbc; i++) begin
            im = nbc - 1 - i;
            for (int k = 0; k < n1c; k++)
               push({l1[im], l0[im]}, {l1[i], l0[i]}, 1'b1, 1'b0, im, i);
         end
         for (int c = 0; c < int'(n2); c++) push({y0, y0}, {y0, y0}, 1'b1, 1'b0, 0, 0);
      end
      push({y0, y0}, {y0, y0}, 1'b0, 1'b1, 0, 0);
   endtask

   always begin
      @(posedge clk);
      if (rst) begin
         q.delete();
         ex.ym = '0; ex.yl = '0; ex.busy = 1'b0; ex.ack = 1'b0; ex.im = '0; ex.il = '0;
      end else if (q.size() > 0) begin
         ex = q.pop_front();
      end else begin
         ex.ym = {y0, y0}; ex.yl = {y0, y0}; ex.busy = 1'b0; ex.ack = 1'b0;
         ex.im = '0; ex.il = '0;
         if (start) build();
      end
      #1;
      vectors++;
      if (y_m !== ex.ym || y_l !== ex.yl || busy_m !== ex.busy || busy_l !== ex.busy ||
          ack_m !== ex.ack || ack_l !== ex.ack || idx_m !== ex.im || idx_l !== ex.il) begin
         miscompares++;
         $display("FAIL cycle t=%0t: got/want y_m=%b/%b y_l=%b/%b busy=%b%b/%b ack=%b%b/%b idx_m=%0d/%0d idx_l=%0d/%0d",
                  $time, y_m, ex.ym, y_l, ex.yl, busy_m, busy_l, ex.busy, ack_m, ack_l, ex.ack,
                  idx_m, ex.im, idx_l, ex.il);
      end
   end

   // Directed frame: issue request, scramble live inputs afterwards, measure
   // ack latency and collect the first repetition's bits from one lane.
   task automatic run_dir(input string name, input int nb, input logic [NC*DW-1:0] d,
                          input int a0, input int a1, input int a2, input int a3,
                          input logic yv, input int exp_lat, input int sel,
                          input logic [15:0] exp_bits, input bit poke);
      int lat, n1c, pos;
      logic [15:0] col;
      nbits = NW'(nb); data = d; n0 = CW'(a0); n1 = CW'(a1); n2 = CW'(a2); n3 = CW'(a3);
      y0 = yv; start = 1'b1;
      col = '0; lat = -1; n1c = (a1 == 0) ? 1 : a1;
      for (int cnt = 0; cnt < exp_lat + 30; cnt++) begin
         @(posedge clk); #1;
         if (cnt == 0) begin
            start = 1'b0;
            data  = $urandom; nbits = NW'($urandom); y0 = ~yv;
            n0 = CW'($urandom_range(0, 9)); n1 = CW'($urandom_range(0, 9));
            n2 = CW'($urandom_range(0, 9)); n3 = CW'($urandom_range(0, 9));
         end
         if (poke && cnt == 5) start = 1'b1;
         if (poke && cnt == 6) start = 1'b0;
         pos = cnt - 1 - a0;
         if (pos >= 0 && (pos % n1c) == 0 && (pos / n1c) < nb)
            col = {col[14:0], (sel == 0) ? y_m[0] : (sel == 1) ? y_l[0] : y_l[1]};
         if (ack_m === 1'b1) begin
            lat = cnt;
            break;
         end
      end
      vectors++;
      if (lat != exp_lat) begin
         miscompares++;
         $display("FAIL %s ack latency: got %0d want %0d", name, lat, exp_lat);
      end
      vectors++;
      if (col !== exp_bits) begin
         miscompares++;
         $display("FAIL %s bit pattern: got %b want %b", name, col, exp_bits);
      end
   endtask

   initial begin
      int acks;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (y_m !== 2'b00 || busy_m !== 1'b0 || ack_m !== 1'b0 || idx_m !== 8'd0) begin
         miscompares++;
         $display("FAIL reset state: got y=%b busy=%b ack=%b idx=%0d want 00 0 0 0",
                  y_m, busy_m, ack_m, idx_m);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      run_dir("msb_lead2", 16, {16'h0000, 16'h5aaa}, 2, 3, 4, 0, 1'b1, 55, 0, 16'h5aaa, 1'b1);
      run_dir("msb_lead1", 16, {16'h0000, 16'h5aaa}, 1, 3, 4, 0, 1'b1, 54, 0, 16'h5aaa, 1'b1);
      run_dir("msb_rep3", 16, {16'h0000, 16'h5aaa}, 0, 3, 4, 2, 1'b1, 157, 0, 16'h5aaa, 1'b1);
      run_dir("lsb_lane1", 4, {16'h000a, 16'h0003}, 0, 1, 0, 0, 1'b0, 5, 2, 16'h0005, 1'b0);
      run_dir("lsb_lane0", 4, {16'h000a, 16'h0003}, 0, 1, 0, 0, 1'b0, 5, 1, 16'h000c, 1'b0);
      run_dir("nbits0", 0, {16'hffff, 16'hffff}, 1, 1, 2, 1, 1'b1, 6, 0, 16'h0000, 1'b0);
      run_dir("n1_zero", 4, {16'h000a, 16'h0003}, 0, 0, 0, 0, 1'b0, 5, 0, 16'h0003, 1'b0);

      // Reset in the middle of the bit phase: abort with no ack
      nbits = 8'd16; data = {16'h0000, 16'h5aaa}; n0 = 2; n1 = 3; n2 = 4; n3 = 0; y0 = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      vectors++;
      if (y_m !== 2'b00 || busy_m !== 1'b0 || busy_l !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset: got y=%b busy=%b%b want 00 00", y_m, busy_m, busy_l);
      end
      acks = 0;
      repeat (60) begin
         @(posedge clk); #1;
         if (ack_m === 1'b1 || ack_l === 1'b1) acks++;
      end
      vectors++;
      if (acks != 0) begin
         miscompares++;
         $display("FAIL mid_reset ack: got %0d acks want 0", acks);
      end
      run_dir("after_rst", 16, {16'h0000, 16'h5aaa}, 2, 3, 4, 0, 1'b1, 55, 0, 16'h5aaa, 1'b0);

      // Randomised traffic: requests, live input churn, occasional reset
      repeat (5000) begin
         @(negedge clk);
         rst   = ($urandom_range(0, 299) == 0);
         start = ($urandom_range(0, 3) == 0);
         data  = $urandom;
         nbits = NW'($urandom_range(0, 20));
         n0    = CW'($urandom_range(0, 3));
         n1    = CW'($urandom_range(0, 3));
         n2    = CW'($urandom_range(0, 3));
         n3    = CW'($urandom_range(0, 2));
         y0    = 1'($urandom);
      end
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/serial_tx_gen.md
Name: serial_tx_gen

Overview:
- Self-timed, parametrised successor to the counter-driven serial transmitter.
- Serialises a latched word onto NCH parallel lanes that share one timing engine.
- Timing comes from an internal counter, with programmable lead-in, bit width, gap and repeat count.
- Start/busy/ack handshake to the control logic; selectable bit order; one clock, feeding board-level serial links.

Parameters:
- DATA_W, 256, max bits per frame per lane.
- NBITS_W, 8, width of nbits input.
- CNT_W, 32, width of timing inputs and internal counter.
- NCH, 1, number of output lanes (each with its own data word).
- LSB_FIRST, 0, 0 = bit nbits-1 sent first; 1 = bit 0 sent first.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request frame; accepted only when busy=0.
- data  in  NCH*DATA_W  lane c uses data[c*DATA_W +: DATA_W].
- nbits  in  NBITS_W  bits per frame.
- y0  in  1  idle/lead/gap line level.
- n0  in  CNT_W  lead-in cycles at idle level before first bit (once per start).
- n1  in  CNT_W  cycles per bit.
- n2  in  CNT_W  gap cycles at idle level after each frame.
- n3  in  CNT_W  extra repeats; frame sent n3+1 times.
- busy  out  1  high from acceptance until ack.
- ack  out  1  one-cycle pulse at completion.
- y  out  NCH  registered serial outputs.
- bit_idx  out  NBITS_W  index of bit currently on y; 0 outside BIT.

Behaviour:
- Reset (synchronous):
  - state=IDLE; busy=0, ack=0, y=0, bit_idx=0; counters cleared.
  - Reset mid-frame aborts immediately with no ack.
- IDLE:
  - y <= {NCH{y0}} every cycle.
  - start=1 at edge k: latch data, nbits, y0, n0..n3 into shadow registers; busy=1 from edge k+1.
  - Later input changes have no effect until the next acceptance.
- start while busy: ignored, not queued.
- Clamping at acceptance:
  - n1=0 is treated as 1.
  - nbits>DATA_W is clamped to DATA_W.
- States and transitions:
  - IDLE -> LEAD if n0>0, else directly to BIT (or GAP if nbits=0).
  - LEAD: y=latched y0 for exactly n0 cycles -> BIT.
  - BIT: each bit held exactly n1 cycles; after nbits bits -> GAP.
  - GAP: y=latched y0 for exactly n2 cycles (n2=0: zero cycles).
  - End of GAP: if repeats remaining -> BIT (no second lead-in), else -> DONE.
  - DONE: one cycle; ack=1, busy=0, y=y0; -> IDLE.
- Timing from acceptance at edge k:
  - First bit appears on y at edge k+1+n0.
  - Bit i of repetition r starts at edge k+1+n0+r*(nbits*n1+n2)+i*n1.
  - ack high for the cycle starting at edge k+1+n0+(n3+1)*(nbits*n1+n2).
  - start may be re-accepted at the edge ending the ack cycle.
- Bit order:
  - LSB_FIRST=0: i-th transmitted bit = data[nbits-1-i].
  - LSB_FIRST=1: i-th transmitted bit = data[i].
  - All lanes are bit-aligned; bit_idx reports the data index being driven.
- nbits=0: no BIT cycles; frame is lead + (n3+1) gaps; ack still pulses.
- Counters:
  - Internal cycle counter is CNT_W bits and reloads per phase; no wrap within a phase.
  - Repeat counter is CNT_W bits; n3=all-ones is legal (long run), abortable only by rst.
- Lead-in and gap levels use the latched y0, not the live input.

Test Plan:
- NCH=1, MSB first; nbits=16, data=16'h5aaa, n0=2, n1=3, n2=4, n3=0, y0=1; start at edge k -> y=1 for 2 cycles; then 0,1,0,1,1,0,1,0,1,0,1,0,1,0,1,0 each 3 cycles; y=1 for 4 cycles; ack pulse at edge k+55; busy high edges k+1..k+54.
- Same data with n0=1, n1=3, n2=4, n3=0 -> first bit at k+2; ack at k+54.
- Same, n0=0, n3=2 -> bit stream repeats 3 times separated by 4-cycle gaps, no lead-in; ack at k+1+3*52=k+157.
- NCH=2, LSB_FIRST=1, nbits=4, lane0=4'b0011, lane1=4'b1010, n1=1, n0=n2=n3=0 -> lane0: 1,1,0,0; lane1: 0,1,0,1; bit_idx 0..3; ack at k+5.
- Edge cases:
  - nbits=0, n0=1, n2=2, n3=1 -> y=y0 throughout; ack at k+6.
  - n1=0 behaves as n1=1.
  - start pulsed while busy -> ignored.
  - rst asserted mid-BIT -> next cycle y=0, busy=0, no ack; new start then works normally.
